// File: rtl/ysyx_mem_pkg.sv
// Shared definitions for the data-memory path: responder FSM encoding,
// default memory-map placement and the full-word store mask.
package ysyx_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h8000_0000;
    localparam logic [3:0]  MASK_WORD      = 4'b1111;
    localparam int unsigned LAT_W          = 4;

    // Unsigned window test; 33-bit compare so a window reaching 2^32 still works.
    function automatic logic addr_in_window(input logic [31:0] offset,
                                            input logic [32:0] window_bytes);
        return ({1'b0, offset} < window_bytes);
    endfunction

endpackage

// File: rtl/ysyx_sram_bytemask.sv
// DEPTH x 32 single-port SRAM: synchronous byte-lane write, synchronous
// read with a registered output, no reset on array or output register.
module ysyx_sram_bytemask #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Read-before-write: on a store the output register picks up the old word,
    // which the responder discards anyway.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int k = 0; k < 4; k++) begin
                if (we_i[k]) begin
                    mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ysyx_dmem_resp.sv
// Data-memory responder: one outstanding valid/ready request, configurable
// wait latency, range check against a fixed window, in-order responses.
module ysyx_dmem_resp
    import ysyx_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE_ADDR,
    parameter int          LATENCY   = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid never waits on ready, ready depends on state only.
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);

    localparam int          IDX_W        = $clog2(DEPTH);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH) << 2;
    localparam logic [LAT_W-1:0] CNT_INIT =
        (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    dmem_state_e      state_q, state_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             wen_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q;
    logic [3:0]       wmask_q;
    logic             err_q;

    logic [31:0]      req_off;
    logic [IDX_W-1:0] req_idx;
    logic             req_in_range;
    logic             latch_en;

    logic             mem_en;
    logic [3:0]       mem_we;
    logic [IDX_W-1:0] mem_addr;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;

    assign req_off      = req_addr_i - BASE_ADDR;
    assign req_idx      = req_off[IDX_W+1:2];
    assign req_in_range = addr_in_window(req_off, WINDOW_BYTES);

    // The array access always lands on the edge that enters RESP: straight
    // from the request inputs when LATENCY is 0, else from the latched copy.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latch_en  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = idx_q;
        mem_wdata = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    latch_en = 1'b1;
                    if (LATENCY == 0) begin
                        state_d   = ST_RESP;
                        mem_en    = req_in_range;
                        mem_we    = (req_wen_i && req_in_range) ? req_wmask_i : 4'b0000;
                        mem_addr  = req_idx;
                        mem_wdata = req_wdata_i;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    mem_en  = ~err_q;
                    mem_we  = (wen_q && !err_q) ? wmask_q : 4'b0000;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wen_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wmask_q <= 4'b0000;
            err_q   <= 1'b0;
        end else if (latch_en) begin
            wen_q   <= req_wen_i;
            idx_q   <= req_idx;
            wdata_q <= req_wdata_i;
            wmask_q <= req_wmask_i;
            err_q   <= ~req_in_range;
        end
    end

    ysyx_sram_bytemask #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (mem_addr),
        .wdata_i (mem_wdata),
        .rdata_o (mem_rdata)
    );

    // SRAM output only moves on an enabled access, so it holds through RESP;
    // gating keeps stores, misses and post-reset cycles at zero.
    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_err_o   = rsp_valid_o & err_q;
    assign rsp_rdata_o = (rsp_valid_o && !wen_q && !err_q) ? mem_rdata : 32'h0;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_dmem_resp.sv
// Directed bench for ysyx_dmem_resp: three instances (LATENCY 2, 3, 0) on a
// shared request bus, responses checked against an expected queue.
module tb_ysyx_dmem_resp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    logic [2:0]  req_valid_v;
    logic [2:0]  rsp_ready_v;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;

    logic [2:0]  req_ready_w;
    logic [2:0]  rsp_valid_w;
    logic [2:0]  rsp_err_w;
    logic [31:0] rsp_rdata_w [3];
    logic [1:0]  dbg_state_w [3];

    logic [32:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int last_acc = 0;

    ysyx_dmem_resp #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(2)) u_l2 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_v[0]), .req_ready_o(req_ready_w[0]),
        .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid_w[0]), .rsp_ready_i(rsp_ready_v[0]),
        .rsp_rdata_o(rsp_rdata_w[0]), .rsp_err_o(rsp_err_w[0]),
        .dbg_state_o(dbg_state_w[0])
    );

    ysyx_dmem_resp #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(3)) u_l3 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_v[1]), .req_ready_o(req_ready_w[1]),
        .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid_w[1]), .rsp_ready_i(rsp_ready_v[1]),
        .rsp_rdata_o(rsp_rdata_w[1]), .rsp_err_o(rsp_err_w[1]),
        .dbg_state_o(dbg_state_w[1])
    );

    ysyx_dmem_resp #(.DEPTH(1024), .BASE_ADDR(32'h8000_0000), .LATENCY(0)) u_l0 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_v[2]), .req_ready_o(req_ready_w[2]),
        .req_wen_i(req_wen), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid_w[2]), .rsp_ready_i(rsp_ready_v[2]),
        .rsp_rdata_o(rsp_rdata_w[2]), .rsp_err_o(rsp_err_w[2]),
        .dbg_state_o(dbg_state_w[2])
    );

    // Sampled at the first falling edge on which rsp_valid is seen:
    // LATENCY+1 edges after the request handshake.
    function automatic int exp_lat(input int s);
        if (s == 0) return 3;
        if (s == 1) return 4;
        return 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int s, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask, output int acc);
        int n;
        n = 0;
        @(negedge clk);
        while (req_ready_w[s] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready_w[s] !== 1'b1) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            acc = -1;
            return;
        end
        req_wen        = wen;
        req_addr       = addr;
        req_wdata      = wdata;
        req_wmask      = mask;
        req_valid_v[s] = 1'b1;
        @(posedge clk);
        #1;
        req_valid_v[s] = 1'b0;
        acc = edges;
    endtask

    task automatic recv(input int s, input int hold);
        int n;
        logic [32:0] e;
        logic [31:0] held;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid_w[s] !== 1'b1 && n < 50);
        if (rsp_valid_w[s] !== 1'b1) begin
            check("rsp_valid_timeout", 32'd0, 32'd1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        check("rsp_latency", n, exp_lat(s));
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata_w[s], e[31:0]);
        check("rsp_err", {31'b0, rsp_err_w[s]}, {31'b0, e[32]});
        held = rsp_rdata_w[s];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'b0, rsp_valid_w[s]}, 32'd1);
            check("bp_rsp_rdata", rsp_rdata_w[s], held);
            check("bp_req_ready", {31'b0, req_ready_w[s]}, 32'd0);
        end
        rsp_ready_v[s] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_v[s] = 1'b0;
        if (hold > 0) begin
            @(negedge clk);
            check("req_ready_after_rsp", {31'b0, req_ready_w[s]}, 32'd1);
            check("rsp_valid_after_rsp", {31'b0, rsp_valid_w[s]}, 32'd0);
        end
    endtask

    task automatic xfer(input int s, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] mask,
                        input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int acc;
        exp_q.push_back({exp_err, exp_rdata});
        send(s, wen, addr, wdata, mask, acc);
        if (acc < 0) begin
            void'(exp_q.pop_back());
            return;
        end
        last_acc = acc;
        recv(s, hold);
    endtask

    initial begin
        int acc;
        int acc_prev;
        logic [31:0] words [4];
        rst         = 1'b1;
        req_valid_v = 3'b000;
        rsp_ready_v = 3'b000;
        req_wen     = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        req_wmask   = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            check("reset_req_ready", {31'b0, req_ready_w[s]}, 32'd1);
            check("reset_rsp_valid", {31'b0, rsp_valid_w[s]}, 32'd0);
            check("reset_rsp_rdata", rsp_rdata_w[s], 32'h0);
            check("reset_rsp_err", {31'b0, rsp_err_w[s]}, 32'd0);
            check("reset_state", {30'b0, dbg_state_w[s]}, 32'd0);
        end
        rst = 1'b0;

        // LATENCY=2: full word, byte lane, empty mask, misaligned, window edges.
        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(0, 1'b1, 32'h8000_0010, 32'h0000_AB00, 4'b0010, 32'h0, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_ABEF, 1'b0, 0);
        xfer(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 32'h0, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0013, 32'h0, 4'b0000, 32'hDEAD_ABEF, 1'b0, 0);
        xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'b0000, 32'h0, 1'b1, 0);
        xfer(0, 1'b1, 32'h8000_0000, 32'h1122_3344, 4'b1111, 32'h0, 1'b0, 0);
        xfer(0, 1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1, 0);
        xfer(0, 1'b0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1122_3344, 1'b0, 0);
        xfer(0, 1'b1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'b1111, 32'h0, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0FFC, 32'h0, 4'b0000, 32'hA5A5_5A5A, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 4'b0000, 32'hDEAD_ABEF, 1'b0, 5);

        // LATENCY=3: reset one cycle after a store is accepted drops the store.
        xfer(1, 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0, 0);
        send(1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'b1111, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midwait_rst_rsp_valid", {31'b0, rsp_valid_w[1]}, 32'd0);
        check("midwait_rst_req_ready", {31'b0, req_ready_w[1]}, 32'd1);
        check("midwait_rst_state", {30'b0, dbg_state_w[1]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("midwait_no_late_rsp", {31'b0, rsp_valid_w[1]}, 32'd0);
        xfer(1, 1'b0, 32'h8000_0020, 32'h0, 4'b0000, 32'hCAFE_F00D, 1'b0, 0);

        // LATENCY=0: fill four words, then read them back-to-back.
        for (int i = 0; i < 4; i++) begin
            words[i] = $urandom_range(32'h7FFF_FFFF, 0) ^ 32'h5A00_0000;
            xfer(2, 1'b1, 32'h8000_0040 + 32'(4 * i), words[i], MASK_WORD_TB(), 32'h0, 1'b0, 0);
        end
        acc_prev = -1;
        for (int i = 0; i < 4; i++) begin
            xfer(2, 1'b0, 32'h8000_0040 + 32'(4 * i), 32'h0, 4'b0000, words[i], 1'b0, 0);
            if (acc_prev >= 0) begin
                check("b2b_spacing", last_acc - acc_prev, 32'd2);
            end
            acc_prev = last_acc;
        end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic [3:0] MASK_WORD_TB();
        return 4'b1111;
    endfunction

endmodule
